// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, decodes Gray-code steps into a
// modulo-2^bits position count with direction, step/wrap pulses and a
// sticky illegal-transition flag.
module quad_decoder #(
    parameter int unsigned bits = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            clr,
    input  logic            load,
    input  logic [bits-1:0] D,
    output logic [bits-1:0] Q,
    output logic            up,
    output logic            step,
    output logic            wrap,
    output logic            err
);

    localparam int unsigned PRIME_W = 2;
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(3);
    localparam logic [bits-1:0]    Q_ONE      = bits'(1);
    localparam logic [bits-1:0]    Q_ALL      = {bits{1'b1}};

    // Synchronizer, previous-sample and priming state
    logic [1:0]         s1_q, s2_q, p_q;
    logic [PRIME_W-1:0] prime_q, prime_d;

    // Architectural state
    logic [bits-1:0] q_q, q_d;
    logic            up_q, up_d;
    logic            step_q, step_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;

    // Decode results
    logic inc_c, dec_c, bad_c, active_c;

    // Classify the {prev, cur} pair as an up step, down step or illegal jump
    always_comb begin
        inc_c = 1'b0;
        dec_c = 1'b0;
        bad_c = 1'b0;
        unique case ({p_q, s2_q})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: inc_c = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: dec_c = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: bad_c = 1'b1;
            default: ;
        endcase
    end

    // Decode is only honoured once the pipeline holds real input samples
    assign active_c = enable && (prime_q == PRIME_DONE);

    // Next-state: clr beats load beats a decoded step
    always_comb begin
        q_d     = q_q;
        up_d    = up_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + PRIME_W'(1);

        if (clr) begin
            q_d   = '0;
            err_d = 1'b0;
        end else if (load) begin
            q_d = D;
            if (active_c && bad_c) begin
                err_d = 1'b1;
            end
        end else if (active_c) begin
            if (inc_c) begin
                q_d    = q_q + Q_ONE;
                up_d   = 1'b1;
                step_d = 1'b1;
                wrap_d = (q_q == Q_ALL);
            end else if (dec_c) begin
                q_d    = q_q - Q_ONE;
                up_d   = 1'b0;
                step_d = 1'b1;
                wrap_d = (q_q == '0);
            end else if (bad_c) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; the input pipeline runs every clock regardless of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= 2'b00;
            s2_q    <= 2'b00;
            p_q     <= 2'b00;
            prime_q <= '0;
            q_q     <= '0;
            up_q    <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= {a_in, b_in};
            s2_q    <= s1_q;
            p_q     <= s2_q;
            prime_q <= prime_d;
            q_q     <= q_d;
            up_q    <= up_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign Q    = q_q;
    assign up   = up_q;
    assign step = step_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: directed scenarios plus randomized traffic,
// checked every cycle against a phase-arithmetic reference model.
module tb_quad_decoder;

    localparam int unsigned BITS = 5;
    localparam int          MOD  = 1 << BITS;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            enable = 1'b0;
    logic            a_in = 1'b0;
    logic            b_in = 1'b0;
    logic            clr = 1'b0;
    logic            load = 1'b0;
    logic [BITS-1:0] D = '0;
    logic [BITS-1:0] Q;
    logic            up, step, wrap, err;

    quad_decoder #(.bits(BITS)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .a_in(a_in), .b_in(b_in),
        .clr(clr), .load(load), .D(D), .Q(Q), .up(up), .step(step), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_q;
    bit         m_up, m_step, m_wrap, m_err;
    logic [1:0] samp[$];
    int         n_edges;
    logic [1:0] cur_ab = 2'b00;
    int         step_cnt, wrap_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Position of an AB pair along the up sequence 00,01,11,10
    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] code_of(input int ph);
        case (ph & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        m_q = 0; m_up = 1'b1; m_step = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
        samp.delete();
        n_edges = 0;
    endtask

    // One rising edge: the count at edge N sees inputs sampled at edges N-2 and N-3
    task automatic model_edge();
        int  delta;
        bit  act;
        samp.push_back({a_in, b_in});
        if (samp.size() > 4) void'(samp.pop_front());
        n_edges++;
        delta = 0;
        if (n_edges >= 4)
            delta = (phase_of(samp[samp.size()-3]) - phase_of(samp[samp.size()-4]) + 4) % 4;
        act = enable && (n_edges >= 4);
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (clr) begin
            m_q = 0; m_err = 1'b0;
        end else if (load) begin
            m_q = int'(D);
            if (act && delta == 2) m_err = 1'b1;
        end else if (act) begin
            if (delta == 1) begin
                m_wrap = (m_q == MOD - 1); m_q = (m_q + 1) % MOD; m_up = 1'b1; m_step = 1'b1;
            end else if (delta == 3) begin
                m_wrap = (m_q == 0); m_q = (m_q + MOD - 1) % MOD; m_up = 1'b0; m_step = 1'b1;
            end else if (delta == 2) begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_q"},    int'(Q),    m_q);
        chk({pfx, "_up"},   int'(up),   int'(m_up));
        chk({pfx, "_step"}, int'(step), int'(m_step));
        chk({pfx, "_wrap"}, int'(wrap), int'(m_wrap));
        chk({pfx, "_err"},  int'(err),  int'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cyc");
        if (step) step_cnt++;
        if (wrap) wrap_cnt++;
    endtask

    task automatic hold(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_ab(input logic [1:0] v);
        cur_ab = v; a_in = v[1]; b_in = v[0];
    endtask

    task automatic move_up();   set_ab(code_of(phase_of(cur_ab) + 1)); endtask
    task automatic move_down(); set_ab(code_of(phase_of(cur_ab) + 3)); endtask

    // Asynchronous reset off the clock edge, held two edges, released on a falling edge
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs("rst_hold");
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        step_cnt = 0;
        wrap_cnt = 0;

        // Reset release with inputs held at 11
        #2;
        set_ab(2'b11);
        enable = 1'b1;
        do_reset();
        hold(6);
        chk("r32_q", int'(Q), 0);
        chk("r32_err", int'(err), 0);
        chk("r32_steps", step_cnt, 0);

        // Four full up cycles from zero
        clr = 1'b1; cycle(); clr = 1'b0;
        step_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            move_up();
            hold(4);
        end
        chk("r33_q", int'(Q), 16);
        chk("r33_up", int'(up), 1);
        chk("r33_steps", step_cnt, 16);

        // Wrap up from all-ones, then wrap down from zero
        load = 1'b1; D = 5'h1F; cycle(); load = 1'b0;
        wrap_cnt = 0;
        move_up(); hold(4);
        chk("r34_q0", int'(Q), 0);
        move_down(); hold(4);
        chk("r34_q1f", int'(Q), 31);
        chk("r34_up", int'(up), 0);
        chk("r34_wraps", wrap_cnt, 2);

        // Illegal jump sets sticky err; valid steps still count; clr clears
        set_ab(~cur_ab); hold(4);
        chk("r35_err", int'(err), 1);
        chk("r35_q", int'(Q), 31);
        move_up(); hold(4);
        chk("r35_q_after", int'(Q), 0);
        chk("r35_err_sticky", int'(err), 1);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("r35_clr_err", int'(err), 0);
        chk("r35_clr_q", int'(Q), 0);

        // Steps while disabled are ignored; re-enable gives no false step
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            move_up();
            hold(4);
        end
        enable = 1'b1;
        step_cnt = 0;
        hold(4);
        chk("r36_q", int'(Q), 0);
        chk("r36_steps", step_cnt, 0);

        // Load on the same edge that would count a down step
        move_down();
        cycle();
        cycle();
        load = 1'b1; D = 5'h0A;
        cycle();
        load = 1'b0;
        chk("r37_q", int'(Q), 10);
        chk("r37_up", int'(up), 1);
        hold(3);

        // Reset mid-step aborts the pending count
        move_up();
        cycle();
        #3;
        do_reset();
        step_cnt = 0;
        hold(6);
        chk("r31_steps", step_cnt, 0);
        chk("r31_q", int'(Q), 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 18)      move_up();
            else if (r < 36) move_down();
            else if (r < 40) set_ab(~cur_ab);
            enable = ($urandom_range(9) != 0);
            clr    = ($urandom_range(49) == 0);
            load   = ($urandom_range(32) == 0);
            D      = BITS'($urandom);
            if ($urandom_range(399) == 0) begin
                clr = 1'b0; load = 1'b0;
                #2;
                do_reset();
            end
            cycle();
        end
        clr = 1'b0; load = 1'b0;
        hold(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter: bits, default 5, width of position count Q and load value D.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 enable  input  1  synchronous active-high count enable.
REQ-005 a_in  input  1  quadrature channel A, asynchronous to clk.
REQ-006 b_in  input  1  quadrature channel B, asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of Q and err.
REQ-008 load  input  1  synchronous load of D into Q.
REQ-009 D  input  bits  load value.
REQ-010 Q  output  bits  registered position count.
REQ-011 up  output  1  registered direction of last valid step (1 = up, 0 = down).
REQ-012 step  output  1  registered one-cycle pulse per counted step.
REQ-013 wrap  output  1  registered one-cycle pulse when Q wraps.
REQ-014 err  output  1  registered sticky illegal-transition flag.

Function
REQ-015 a_in and b_in SHALL each pass through a 2-flop synchronizer (s1, s2), then a previous-state register (p); all three update every clock, regardless of enable.
REQ-016 Decode SHALL compare {A,B} of s2 (cur) against p (prev), combinationally, evaluated at each edge.
REQ-017 Up sequence (AB): 00->01->11->10->00; each such step SHALL increment Q by 1 and set up=1.
REQ-018 Down sequence: 00->10->11->01->00; each such step SHALL decrement Q by 1 and set up=0.
REQ-019 cur==prev SHALL cause no change to Q or up; step=0.
REQ-020 Two-bit change (00<->11, 01<->10) SHALL set err=1 and leave Q and up unchanged; step=0.
REQ-021 Latency: input change setup before edge N SHALL update Q at edge N+2 (s1 at N, s2 at N+1, decode/count at N+2), step high for the cycle after edge N+2.
REQ-022 Arithmetic SHALL be modulo 2^bits: up from all-ones gives 0 with wrap=1; down from 0 gives all-ones with wrap=1; wrap=0 otherwise.
REQ-023 Priority per edge: clr > load > decoded step.
REQ-024 clr=1: Q=0, err=0, step=0, wrap=0; up unchanged; independent of enable.
REQ-025 load=1 (clr=0): Q=D, step=0, wrap=0; simultaneous valid step is discarded, up unchanged; independent of enable; err may still be set by an illegal transition that edge.
REQ-026 enable=0: decoded steps and illegal transitions SHALL be ignored (no Q, up, err, step, wrap change); s1/s2/p keep tracking so re-enable produces no false step.
REQ-027 step and wrap SHALL be 0 on every edge not counting a valid step.
REQ-028 err SHALL remain 1 until clr or reset.

Reset
REQ-029 reset_n=0 SHALL immediately force Q=0, up=1, step=0, wrap=0, err=0, s1=s2=p=00.
REQ-030 A 2-bit prime counter SHALL be cleared by reset; decode SHALL be suppressed (no count, no err) for the first 3 edges after reset_n deasserts, so p holds true input before evaluation.
REQ-031 Reset asserted mid-operation SHALL abort any pending step; no step or wrap pulse after release until a new transition follows priming.

Verification
REQ-032 Reset release with a_in=b_in=1 held, enable=1 -> after 3 edges Q=0, err=0, step never pulses.
REQ-033 bits=5, Q=0, drive 4 up-cycles (16 edges of input, one change per 4 clocks) -> Q=16, up=1, 16 step pulses, each 2 edges after its input change.
REQ-034 load D=5'h1F, then one up step -> Q=0, wrap=1 for one cycle; then one down step -> Q=5'h1F, wrap=1, up=0.
REQ-035 Jump 00->11 with enable=1 -> err=1, Q unchanged, step=0; err stays 1 through further valid steps (which still count); clr -> err=0, Q=0.
REQ-036 enable=0 during 3 up steps, then enable=1 with inputs stationary -> Q unchanged, no step pulse.
REQ-037 load=1 and valid down step on same edge, D=5'h0A -> Q=5'h0A, step=0, up unchanged.
